dram_port_arbiter: RTL
======================

# dram_port_arbiter

Shares the single data-RAM port between N processor cores and the external load/readback port. It replaces ad-hoc priority muxing of core and external address/data/enable signals in the multicore top level. The external port has fixed highest priority; cores are served round-robin, one RAM access per clock. Read data is returned with a per-requester valid strobe aligned to the RAM's one-cycle synchronous read.

## Interface
Parameters
- N_CORES, 2, number of core requesters (2..8)
- ADDR_W, 9, data-RAM address width
- DATA_W, 16, data word width

Ports
- clock  in  1  single clock; all state changes on posedge
- reset  in  1  asynchronous, active-high reset
- req  in  N_CORES  per-core access request, level, held until granted
- we  in  N_CORES  per-core 1 = write, 0 = read; valid while req high
- addr  in  N_CORES*ADDR_W  core i address at [i*ADDR_W +: ADDR_W]
- wdata  in  N_CORES*DATA_W  core i write data at [i*DATA_W +: DATA_W]
- gnt  out  N_CORES  one-hot registered grant pulse, 1 cycle
- rvalid  out  N_CORES  one-hot registered read-data-valid pulse
- ext_req, ext_we  in  1 each  external port request / write select
- ext_addr  in  ADDR_W;  ext_wdata  in  DATA_W
- ext_gnt, ext_rvalid  out  1 each  external grant / read valid
- rdata  out  DATA_W  read data, shared by all requesters; equals ram_rdata
- ram_en, ram_we  out  1 each  RAM enable / write enable, registered
- ram_addr  out  ADDR_W;  ram_wdata  out  DATA_W  registered RAM command
- ram_rdata  in  DATA_W  RAM synchronous read output
- conflict_cnt  out  16  saturating count of cycles with ≥2 eligible requesters

## Operation
- Eligible set: ext_req, plus req[i] & ~gnt[i]. A requester is masked during the cycle its own gnt is high, so a held req is never double-issued.
- Selection each cycle, combinational from the eligible set and the pointer `last`:
  - If ext eligible: select ext.
  - Else: select the first eligible core searching last+1, last+2, … mod N_CORES.
  - If nothing is eligible: idle.
- On the edge after selection:
  - ram_en=1.
  - ram_we, ram_addr and ram_wdata take the selected requester's values.
  - The matching gnt/ext_gnt bit goes high for exactly one cycle.
  - `last` is updated to the granted core index. Ext grants and idle cycles leave `last` unchanged.
- Idle cycle: ram_en=0 and ram_we=0. ram_addr and ram_wdata hold their previous values.
- Read return: one edge after a read command is registered, rvalid[i] or ext_rvalid pulses for one cycle. rdata during that cycle is the word read.
- Writes produce no rvalid.
- conflict_cnt increments when 2 or more requesters are eligible in a cycle. It saturates at 16'hFFFF.
- Requester rule: addr, wdata and we must be stable from req rise through the gnt cycle. req may be dropped in the gnt cycle or re-asserted for the next access.

## Timing
- Reset (asynchronous, immediate) drives:
  - gnt=0, ext_gnt=0, rvalid=0, ext_rvalid=0
  - ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0
  - conflict_cnt=0
  - last=N_CORES-1, so core 0 wins first.
- Latency, req to gnt: request sampled at edge E0; gnt and RAM command high after E0. With no contention this is 1 cycle.
- Latency, read data: RAM samples at E1; rvalid and rdata valid after E1. Read data therefore arrives 2 cycles after req is sampled.
- Throughput: one access per cycle in total. Each individual core gets at most one grant per 2 cycles.
- Worst-case core wait: N_CORES cycles, or longer while ext_req is held. External traffic may starve cores by design; loading and readback happen with the cores halted.
- Simultaneous events: ext and all cores requesting at once gives ext first, then cores in round-robin order. A read grant followed by a write grant back-to-back is legal; rvalid for the read still appears one edge later.
- Reset mid-operation aborts any pending rvalid. The RAM command in flight is dropped because ram_en is forced to 0.
- Pointer wrap-around: after core N_CORES-1 is granted, the search starts at core 0.

## Test plan
- Reset with req=2'b11 held: after release, gnt sequence is 01, 10, 01, 10 on alternating cycles. conflict_cnt counts only cycles with 2 eligible requesters.
- Core 0 writes 16'hA5A5 to 9'h010, then reads 9'h010 → rvalid[0]=1 with rdata=16'hA5A5 exactly 2 cycles after the read req is sampled. rvalid[1] stays 0.
- ext_req read of 9'h1FF while both cores request → ext_gnt on the first cycle. Cores are then served round-robin and `last` is unaffected by the ext grant.
- Core 1 alone, req held for 6 cycles → 3 grants on alternating cycles with no duplicate RAM command. ram_en=0 between them.
- Force conflict_cnt to 16'hFFFE via contention, then 3 more conflict cycles → count stays at 16'hFFFF.
- Assert reset in the cycle after a read grant → ram_en and rvalid drop immediately. No rvalid appears after release; first grant goes to core 0.

Source files
------------

// File: rtl/dram_port_arbiter.sv
// Shares the single data-RAM port between N cores (round-robin) and the external
// load/readback port (fixed highest priority); returns per-requester read-valid strobes.
module dram_port_arbiter #(
   parameter int N_CORES = 2,
   parameter int ADDR_W  = 9,
   parameter int DATA_W  = 16
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [N_CORES-1:0]         req,
   input  logic [N_CORES-1:0]         we,
   input  logic [N_CORES*ADDR_W-1:0]  addr,
   input  logic [N_CORES*DATA_W-1:0]  wdata,
   output logic [N_CORES-1:0]         gnt,
   output logic [N_CORES-1:0]         rvalid,
   input  logic                       ext_req,
   input  logic                       ext_we,
   input  logic [ADDR_W-1:0]          ext_addr,
   input  logic [DATA_W-1:0]          ext_wdata,
   output logic                       ext_gnt,
   output logic                       ext_rvalid,
   output logic [DATA_W-1:0]          rdata,
   output logic                       ram_en,
   output logic                       ram_we,
   output logic [ADDR_W-1:0]          ram_addr,
   output logic [DATA_W-1:0]          ram_wdata,
   input  logic [DATA_W-1:0]          ram_rdata,
   output logic [15:0]                conflict_cnt
);

   localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

   logic [ADDR_W-1:0]  core_addr  [N_CORES];
   logic [DATA_W-1:0]  core_wdata [N_CORES];
   logic [N_CORES-1:0] core_elig;

   logic [N_CORES-1:0] gnt_reg, gnt_next;
   logic [N_CORES-1:0] rvalid_reg;
   logic               ext_gnt_reg, ext_rvalid_reg;
   logic               ram_en_reg, ram_we_reg;
   logic [ADDR_W-1:0]  ram_addr_reg;
   logic [DATA_W-1:0]  ram_wdata_reg;
   logic [15:0]        conflict_cnt_reg;
   logic [IDX_W-1:0]   last_reg;

   logic               core_found;
   logic [IDX_W-1:0]   sel_idx;
   logic [IDX_W:0]     cand;
   logic               sel_we;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_wdata;
   logic               any_sel;
   logic               conflict;
   int                 elig_total;

   for (genvar gi = 0; gi < N_CORES; gi++) begin : g_unpack
      assign core_addr[gi]  = addr[gi*ADDR_W +: ADDR_W];
      assign core_wdata[gi] = wdata[gi*DATA_W +: DATA_W];
   end

   // A core is masked in its own grant cycle so a held req is not issued twice.
   assign core_elig = req & ~gnt_reg;

   always_comb begin
      core_found = 1'b0;
      sel_idx    = last_reg;
      cand       = '0;
      for (int k = 1; k <= N_CORES; k++) begin
         cand = {1'b0, last_reg} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(N_CORES))
            cand = cand - (IDX_W+1)'(N_CORES);
         if (!core_found && core_elig[cand[IDX_W-1:0]]) begin
            core_found = 1'b1;
            sel_idx    = cand[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      elig_total = 0;
      for (int k = 0; k < N_CORES; k++)
         elig_total = elig_total + int'(core_elig[k]);
      if (ext_req)
         elig_total = elig_total + 1;
   end

   assign conflict = (elig_total >= 2);
   assign any_sel  = ext_req | core_found;

   always_comb begin
      sel_we    = ext_we;
      sel_addr  = ext_addr;
      sel_wdata = ext_wdata;
      gnt_next  = '0;
      if (!ext_req) begin
         sel_we    = we[sel_idx];
         sel_addr  = core_addr[sel_idx];
         sel_wdata = core_wdata[sel_idx];
         if (core_found)
            gnt_next[sel_idx] = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         gnt_reg          <= '0;
         ext_gnt_reg      <= 1'b0;
         rvalid_reg       <= '0;
         ext_rvalid_reg   <= 1'b0;
         ram_en_reg       <= 1'b0;
         ram_we_reg       <= 1'b0;
         ram_addr_reg     <= '0;
         ram_wdata_reg    <= '0;
         conflict_cnt_reg <= '0;
         last_reg         <= IDX_W'(N_CORES-1);
      end else begin
         gnt_reg     <= gnt_next;
         ext_gnt_reg <= ext_req;
         ram_en_reg  <= any_sel;
         ram_we_reg  <= any_sel & sel_we;
         if (any_sel) begin
            ram_addr_reg  <= sel_addr;
            ram_wdata_reg <= sel_wdata;
         end
         // The command registered last cycle is sampled by the RAM now; reads return next.
         rvalid_reg     <= ram_we_reg ? '0 : gnt_reg;
         ext_rvalid_reg <= ext_gnt_reg & ~ram_we_reg;
         if (!ext_req && core_found)
            last_reg <= sel_idx;
         if (conflict && (conflict_cnt_reg != 16'hFFFF))
            conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
      end
   end

   assign gnt          = gnt_reg;
   assign ext_gnt      = ext_gnt_reg;
   assign rvalid       = rvalid_reg;
   assign ext_rvalid   = ext_rvalid_reg;
   assign ram_en       = ram_en_reg;
   assign ram_we       = ram_we_reg;
   assign ram_addr     = ram_addr_reg;
   assign ram_wdata    = ram_wdata_reg;
   assign conflict_cnt = conflict_cnt_reg;
   assign rdata        = ram_rdata;

endmodule
